spu_seq: RTL and testbench
==========================

SPU_SEQ -- requirements
Module: spu_seq

Interface
REQ-001 SHALL have no parameters; internal fixed-point format is fixed at unsigned Q16.16 magnitude plus a separate sign bit.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 x_float  input  32  IEEE-754 single-precision operand, sampled on input handshake.
REQ-006 in_valid  input  1  operand present.
REQ-007 in_ready  output  1  unit idle and able to accept; equals (state==IDLE) and is 0 while rst_n low.
REQ-008 y_float  output  32  IEEE-754 single result, sigmoid(x), registered.
REQ-009 out_valid  output  1  y_float valid; high only in DONE.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement the forward (float -> sigmoid -> float) counterpart of the inverse-sigmoid unit, as an FSM with states IDLE, CONV, EVAL, NORM and DONE.
REQ-013 IDLE: on in_valid && in_ready at a clock edge, SHALL capture x_float and enter CONV; in_valid is ignored in all other states.
REQ-014 CONV (1 cycle): e = exp - 127. Magnitude rules:
  - exp==0 -> 0.
  - e < -16 -> 0.
  - e >= 15 or exp==255 with frac==0 -> 0xFFFF_FFFF.
  - otherwise m = {1,frac}, shifted left by (e-7) or right by (7-e), truncating.
  Sign = bit 31. Next state EVAL.
REQ-015 NaN input (exp==255, frac!=0): CONV SHALL load y_float=0x7FC0_0000 and go directly to DONE.
REQ-016 EVAL (1 cycle): SHALL compute p = PLAN(|x|) in Q16.16 using shifts and adds only:
  - |x| >= 5.0: p = 1.0.
  - 2.375 <= |x| < 5: p = (|x|>>5) + 0.84375.
  - 1.0 <= |x| < 2.375: p = (|x|>>3) + 0.625.
  - |x| < 1.0: p = (|x|>>2) + 0.5.
  Then y = p if sign=0, else y = 1.0 - p. Load exponent register with 127. Next state NORM.
REQ-017 NORM (iterative normalisation), one action per cycle:
  - y==0: y_float = 0x0000_0000, go to DONE.
  - y[16]==1: y_float = {0, exp[7:0], y[15:0], 7'b0}, go to DONE.
  - otherwise: y <<= 1, exp -= 1, stay in NORM.
REQ-018 NORM SHALL make at most 16 shifts (k); cycles spent in NORM = k+1.
REQ-019 Latency: out_valid SHALL rise 4+k cycles after the input handshake edge, or 2 cycles after it for NaN input.
REQ-020 DONE: out_valid=1 and y_float held stable until out_ready=1 at an edge; then go to IDLE with out_valid=0. No back-to-back acceptance, so in_ready is 0 on the cycle of the output handshake.
REQ-021 out_ready is ignored outside DONE; holding out_ready high continuously SHALL cost no extra cycle.
REQ-022 Mantissa rounding SHALL be truncation throughout; -0.0 SHALL give the same result as +0.0.

Reset
REQ-023 On rst_n low, asynchronously:
  - state = IDLE
  - out_valid = 0
  - y_float = 0x0000_0000
  - busy = 0
  - internal fixed, exponent and sign registers = 0
REQ-024 Assertion of rst_n mid-operation (any state) SHALL abort the operation with no output; first accept is possible on the first edge after deassertion.

Verification
REQ-025 x=0x0000_0000 -> y=0x3F00_0000 (0.5), k=1, out_valid 5 cycles after handshake.
REQ-026 x=0x3F80_0000 (1.0) -> 0x3F40_0000 (0.75); x=0xBF80_0000 (-1.0) -> 0x3E80_0000 (0.25), k=2, latency 6.
REQ-027 x=0x40C0_0000 (6.0) -> 0x3F80_0000, latency 4; x=0xC100_0000 (-8.0) -> 0x0000_0000, latency 4; x=0x7F80_0000 (+inf) -> 0x3F80_0000.
REQ-028 x=0x7FC0_0001 (NaN) -> 0x7FC0_0000, out_valid 2 cycles after handshake.
REQ-029 x=0x4000_0000 (2.0) with out_ready low for 10 cycles -> y=0x3F60_0000 held stable, in_ready=0 throughout; release -> IDLE next edge.
REQ-030 rst_n pulsed low during NORM -> out_valid never asserts, in_ready=0 during reset, then 1; next operand processed correctly.

Source files
------------

// File: rtl/spu_seq.sv
// spu_seq: sequential float -> sigmoid -> float unit.
// The operand is converted to Q16.16 magnitude plus sign, passed through a
// piecewise-linear sigmoid approximation (shifts and adds only), then
// normalised one bit per cycle back into IEEE-754 single precision.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   x_float    IEEE-754 single operand, captured on in_valid && in_ready
//   in_valid   operand present
//   in_ready   unit idle and able to accept (0 while in reset)
//   y_float    registered IEEE-754 single result
//   out_valid  y_float valid (DONE state only)
//   out_ready  consumer accepts result
//   busy       unit is in any state other than IDLE
module spu_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] x_float,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y_float,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    localparam int unsigned W = 32;

    localparam logic [W-1:0] ONE_Q     = 32'h0001_0000;
    localparam logic [W-1:0] FIVE_Q    = 32'h0005_0000;
    localparam logic [W-1:0] T2375_Q   = 32'h0002_6000;
    localparam logic [W-1:0] C084375_Q = 32'h0000_D800;
    localparam logic [W-1:0] C0625_Q   = 32'h0000_A000;
    localparam logic [W-1:0] HALF_Q    = 32'h0000_8000;
    localparam logic [W-1:0] QNAN      = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CONV = 3'd1,
        EVAL = 3'd2,
        NORM = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t         state;
    logic [W-1:0]   x_reg;
    logic [W-1:0]   fx;
    logic           sign;
    logic [7:0]     exp_r;

    logic [7:0]        xe;
    logic [22:0]       xf;
    logic signed [9:0] e_c;
    logic [W-1:0]      m32;
    logic              is_nan_c;
    logic [W-1:0]      mag_c;
    logic [W-1:0]      p_c;
    logic [W-1:0]      y_c;

    assign in_ready = (state == IDLE) && rst_n;
    assign busy     = (state != IDLE);

    assign xe       = x_reg[30:23];
    assign xf       = x_reg[22:0];
    assign e_c      = $signed({2'b00, xe}) - 10'sd127;
    assign m32      = {8'h00, 1'b1, xf};
    assign is_nan_c = (xe == 8'hFF) && (xf != 23'd0);

    // Float magnitude to Q16.16: value = m * 2^(e-23), scaled by 2^16.
    always_comb begin
        mag_c = '0;
        if (xe == 8'h00) begin
            mag_c = '0;
        end else if (xe == 8'hFF) begin
            mag_c = '1;
        end else if (e_c < -10'sd16) begin
            mag_c = '0;
        end else if (e_c >= 10'sd15) begin
            mag_c = '1;
        end else if (e_c >= 10'sd7) begin
            mag_c = m32 << 5'(e_c - 10'sd7);
        end else begin
            mag_c = m32 >> 5'(10'sd7 - e_c);
        end
    end

    // Piecewise-linear sigmoid on |x|; negative inputs use symmetry 1 - p.
    always_comb begin
        p_c = HALF_Q;
        if (fx >= FIVE_Q) begin
            p_c = ONE_Q;
        end else if (fx >= T2375_Q) begin
            p_c = (fx >> 5) + C084375_Q;
        end else if (fx >= ONE_Q) begin
            p_c = (fx >> 3) + C0625_Q;
        end else begin
            p_c = (fx >> 2) + HALF_Q;
        end
        y_c = sign ? (ONE_Q - p_c) : p_c;
    end

    // Sequencer with registered result and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x_reg     <= '0;
            fx        <= '0;
            sign      <= 1'b0;
            exp_r     <= 8'd0;
            y_float   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg <= x_float;
                        state <= CONV;
                    end
                end
                CONV: begin
                    sign <= x_reg[31];
                    if (is_nan_c) begin
                        y_float   <= QNAN;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        fx    <= mag_c;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    fx    <= y_c;
                    exp_r <= 8'd127;
                    state <= NORM;
                end
                NORM: begin
                    // y <= 1.0, so bit 16 is the implicit leading one.
                    if (fx == '0) begin
                        y_float   <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (fx[16]) begin
                        y_float   <= {1'b0, exp_r, fx[15:0], 7'b0};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        fx    <= {fx[W-2:0], 1'b0};
                        exp_r <= exp_r - 8'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spu_seq.sv
// tb_spu_seq: directed scoreboard bench for spu_seq.
// Latency is counted in rising edges, the handshake edge being edge 1.
module tb_spu_seq;

    logic        clk;
    logic        rst_n;
    logic [31:0] x_float;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y_float;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] y;
        int          lat;
    } exp_t;

    exp_t sb[$];

    spu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_float   (x_float),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_float   (y_float),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One transaction: handshake, measure latency, optional backpressure, release.
    task automatic op(input logic [31:0] x, input logic [31:0] ey, input int elat,
                      input int hold, input bit early);
        exp_t        e;
        int          lat;
        logic [31:0] held;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        x_float   = x;
        in_valid  = 1'b1;
        out_ready = early;
        sb.push_back('{y: ey, lat: elat});
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        x_float  = $urandom;
        chk("busy_after_accept", 32'(busy), 32'd1);
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("out_valid_seen", 32'(out_valid), 32'd1);
        e = sb.pop_front();
        chk("y_float", y_float, e.y);
        chk("latency", 32'(lat), 32'(e.lat));
        chk("in_ready_done", 32'(in_ready), 32'd0);
        held = y_float;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            x_float  = $urandom;
            @(posedge clk);
            @(negedge clk);
            chk("hold_y", y_float, held);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_busy", 32'(busy), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        x_float   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", y_float, 32'h0000_0000);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op(32'h0000_0000, 32'h3F00_0000, 5, 0, 1'b0);  // 0.0
        op(32'h8000_0000, 32'h3F00_0000, 5, 0, 1'b0);  // -0.0
        op(32'h3F80_0000, 32'h3F40_0000, 5, 0, 1'b0);  // 1.0
        op(32'hBF80_0000, 32'h3E80_0000, 6, 0, 1'b0);  // -1.0
        op(32'h40C0_0000, 32'h3F80_0000, 4, 0, 1'b1);  // 6.0, out_ready held high
        op(32'hC100_0000, 32'h0000_0000, 4, 0, 1'b0);  // -8.0
        op(32'h7F80_0000, 32'h3F80_0000, 4, 0, 1'b0);  // +inf
        op(32'h7FC0_0001, 32'h7FC0_0000, 2, 0, 1'b0);  // NaN
        op(32'hFFC0_0000, 32'h7FC0_0000, 2, 0, 1'b1);  // negative NaN
        op(32'h4000_0000, 32'h3F60_0000, 5, 10, 1'b0); // 2.0 with backpressure
        op(32'h3F00_0000, 32'h3F20_0000, 5, 0, 1'b0);  // 0.5
        op(32'h4040_0000, 32'h3F70_0000, 5, 0, 1'b0);  // 3.0
        op(32'hC040_0000, 32'h3D80_0000, 8, 0, 1'b0);  // -3.0, four shifts
        op(32'h4018_0000, 32'h3F6B_0000, 5, 0, 1'b0);  // 2.375 breakpoint
        op(32'h40A0_0000, 32'h3F80_0000, 4, 0, 1'b0);  // 5.0 breakpoint
        op(32'h4700_0000, 32'h3F80_0000, 4, 0, 1'b0);  // 32768.0 saturates
        op(32'h3700_0000, 32'h3F00_0000, 5, 0, 1'b0);  // 2^-17 underflows

        // Reset abort while in NORM (-3.0 stays in NORM for five cycles).
        @(negedge clk);
        x_float  = 32'hC040_0000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_y", y_float, 32'h0000_0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_abort_valid", 32'(out_valid), 32'd0);
            chk("post_abort_in_ready", 32'(in_ready), 32'd1);
        end
        op(32'h4000_0000, 32'h3F60_0000, 5, 0, 1'b0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
